seq_shifter: RTL and testbench
==============================

# seq_shifter

Multi-cycle, one-bit-per-cycle shift unit for the 8-bit datapath. It is the sequential counterpart of the single-cycle combinational shifter. It accepts an operand and shift descriptor through a start/ready handshake and shifts one position per clock. It reports completion with a one-cycle `done` pulse and the last bit shifted out as `cout`. It sits beside the ALU for area-constrained builds and for instructions that need the carry-out flag.

## Interface

- `WIDTH`, default 8: operand width. The count width is derived internally as clog2(WIDTH).
- `clk`, input, 1: the single clock. All state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: request. Accepted on a rising edge when `start && ready`.
- `data_in`, input, WIDTH: operand, captured at acceptance.
- `shift_by`, input, clog2(WIDTH): shift amount, 0..WIDTH-1, captured at acceptance.
- `lr`, input, 1: direction, 0 = left, 1 = right.
- `arith`, input, 1: right-shift fill, 0 = zero fill, 1 = replicate MSB. Ignored for left shifts.
- `rot`, input, 1: rotate request. Only honoured with the macro described under Configuration.
- `ready`, output, 1: the unit can accept a request this cycle.
- `done`, output, 1: one-cycle pulse; `data_out` and `cout` are valid.
- `data_out`, output, WIDTH: result. Held from `done` until the next acceptance.
- `cout`, output, 1: last bit shifted out. 0 when `shift_by` is 0.

## Operation

- States and transitions:
  - IDLE → LOAD-then-SHIFT on acceptance.
  - SHIFT → DONE when the remaining count reaches 0.
  - DONE → IDLE, or directly into a new operation if `start` is high in DONE.
- Acceptance:
  - Latch `data_in` into the working register, `shift_by` into the down-counter, and `lr`/`arith`/`rot` into the op register.
  - If `shift_by` is 0, go straight to DONE.
- Each SHIFT cycle:
  - Left: register shifts left, LSB filled with 0, `cout` ← old MSB.
  - Right logical: MSB filled with 0, `cout` ← old LSB.
  - Right arithmetic: MSB filled with the old MSB, `cout` ← old LSB.
  - Counter decrements by 1.
- `ready` is 1 in IDLE and DONE, 0 in SHIFT.
  - `start` while `ready` is 0 is ignored; no queuing.
  - Input changes after acceptance have no effect.
- `data_out` is the working register. It is not guaranteed meaningful while in SHIFT, so consumers sample only on `done`.
- Reset values: `ready` 1, `done` 0, `data_out` 0, `cout` 0, state IDLE, counter 0.
- Reset asserted mid-operation: immediate return to reset values. No `done` is produced for the aborted operation.

## Timing

- Acceptance at edge t; `done` is high during the cycle following edge t+N, where N = captured `shift_by`.
  - N = 0 gives `done` one cycle after acceptance.
  - Worst-case latency is WIDTH cycles (8 for the default).
- Back-to-back: `start` held high during DONE is accepted on that edge, so issue interval is N+1 cycles.
- `done` is never high for two consecutive cycles unless two operations with N = 0 are issued back-to-back.
- All outputs are registered; no combinational path from inputs to outputs except `ready` from state.

## Configuration

- Macro `SEQ_SHIFTER_ROTATE_EN`.
- Defined:
  - `rot` = 1 selects rotate; the bit leaving the register re-enters at the vacated end.
  - `cout` = that bit, as for a normal shift.
  - `rot` takes priority over `arith`.
- Undefined:
  - `rot` is ignored and treated as 0; the port remains present so the top-level connections are identical.
  - No rotate logic is synthesized.

## Structure

- Shared package `seq_shifter_pkg` holds:
  - the state enum (IDLE, SHIFT, DONE);
  - direction constants SHIFT_LEFT = 0, SHIFT_RIGHT = 1;
  - the op-register struct {lr, arith, rot}.
- One natural sub-module: `shift_step`. It is a combinational single-position step taking register, op struct, and producing next register and out-bit. The FSM/counter stays in `seq_shifter`.

## Test plan

- `data_in` 0x96, `shift_by` 3, left → `data_out` 0xB0, `cout` 0, `done` 4 cycles after acceptance; `ready` low for cycles 1–3.
- 0x96, `shift_by` 2, right, `arith` 1 → 0xE5, `cout` 1, `done` at +3. Same with `arith` 0 → 0x25, `cout` 1.
- 0x96, `shift_by` 7, right logical → 0x01, `cout` 0, `done` at +8.
- 0x5A, `shift_by` 0 → 0x5A, `cout` 0, `done` at +1. A second `start` held during DONE (0x01, left 1) is accepted → 0x02 one issue interval later.
- Rotate case, 0x81, left, `shift_by` 1, `rot` 1:
  - With `SEQ_SHIFTER_ROTATE_EN` → 0x03, `cout` 1.
  - Without it → 0x02, `cout` 1.
- Reset abort: `rst_n` low two cycles into a `shift_by` 6 operation → `ready` 1, `data_out` 0, `cout` 0 immediately, and no `done` afterwards. A `start` pulsed during SHIFT of another operation is ignored and that operation's result is unchanged.

Source files
------------

// File: rtl/seq_shifter_pkg.sv
// Shared types for seq_shifter: FSM states, shift direction constants and the captured op descriptor.
package seq_shifter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic SHIFT_LEFT  = 1'b0;
  localparam logic SHIFT_RIGHT = 1'b1;

  typedef struct packed {
    logic lr;
    logic arith;
    logic rot;
  } op_t;

endpackage

// File: rtl/seq_shifter_shift_step.sv
// Combinational single-position shift/rotate step; zero latency, no flow control.
// Rotation is only built when SEQ_SHIFTER_ROTATE_EN is defined; otherwise op.rot is ignored.
module shift_step
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur,
  input  op_t              op,
  output logic [WIDTH-1:0] nxt,
  output logic             out_bit
);

  logic do_rot;
  logic fill;

`ifdef SEQ_SHIFTER_ROTATE_EN
  assign do_rot = op.rot;
`else
  logic unused_rot;
  assign unused_rot = op.rot;
  assign do_rot     = 1'b0;
`endif

  always_comb begin
    fill    = 1'b0;
    nxt     = cur;
    out_bit = 1'b0;
    if (op.lr == SHIFT_LEFT) begin
      fill    = do_rot ? cur[WIDTH-1] : 1'b0;
      nxt     = {cur[WIDTH-2:0], fill};
      out_bit = cur[WIDTH-1];
    end else begin
      // Rotate wins over arithmetic fill.
      fill    = do_rot ? cur[0] : (op.arith ? cur[WIDTH-1] : 1'b0);
      nxt     = {fill, cur[WIDTH-1:1]};
      out_bit = cur[0];
    end
  end

endmodule

// File: rtl/seq_shifter.sv
// One-bit-per-clock shifter: done pulses N clocks after acceptance; ready low while shifting, start ignored then.
// Optional rotate support is enabled with the SEQ_SHIFTER_ROTATE_EN macro.
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [CW-1:0]    shift_by,
  input  logic             lr,
  input  logic             arith,
  input  logic             rot,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] data_out,
  output logic             cout
);

  state_t           state;
  logic [CW-1:0]    cnt;
  op_t              op_q;
  logic [WIDTH-1:0] step_nxt;
  logic             step_bit;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .cur     (data_out),
    .op      (op_q),
    .nxt     (step_nxt),
    .out_bit (step_bit)
  );

  assign ready = (state != SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= '0;
      data_out <= '0;
      cout     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // DONE accepts a new request exactly like IDLE, giving an N+1 issue interval.
        IDLE, DONE: begin
          if (start) begin
            data_out   <= data_in;
            cnt        <= shift_by;
            op_q.lr    <= lr;
            op_q.arith <= arith;
            op_q.rot   <= rot;
            cout       <= 1'b0;
            if (shift_by == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          data_out <= step_nxt;
          cout     <= step_bit;
          cnt      <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: directed plan vectors, back-to-back, ignored start, reset abort, random ops.
module tb_seq_shifter;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [2:0]   shift_by = '0;
  logic         lr = 1'b0;
  logic         arith = 1'b0;
  logic         rot = 1'b0;
  logic         ready;
  logic         done;
  logic [W-1:0] data_out;
  logic         cout;

  int cmp = 0;
  int mis = 0;

  seq_shifter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .data_in  (data_in),
    .shift_by (shift_by),
    .lr       (lr),
    .arith    (arith),
    .rot      (rot),
    .ready    (ready),
    .done     (done),
    .data_out (data_out),
    .cout     (cout)
  );

  always #5 clk = ~clk;

  // Reference: whole-operation result from shift arithmetic, returns {cout, result}.
  function automatic logic [W:0] model(input logic [W-1:0] d, input int n,
                                       input logic l, input logic a, input logic r);
    logic [W-1:0] res;
    logic         c;
    logic         rot_en;
`ifdef SEQ_SHIFTER_ROTATE_EN
    rot_en = r;
`else
    rot_en = 1'b0;
`endif
    if (n == 0) begin
      res = d;
      c   = 1'b0;
    end else if (l == 1'b0) begin
      c   = d[W-n];
      res = rot_en ? ((d << n) | (d >> (W - n))) : (d << n);
    end else begin
      c = d[n-1];
      if (rot_en)  res = (d >> n) | (d << (W - n));
      else if (a)  res = W'($signed(d) >>> n);
      else         res = d >> n;
    end
    return {c, res};
  endfunction

  // Caller is positioned at a negedge; returns at the negedge of the DONE cycle.
  task automatic run_op(input logic [W-1:0] d, input int n, input logic l, input logic a,
                        input logic r, input logic [W-1:0] ed, input logic ec,
                        input bit pulse, input string nm);
    data_in = d; shift_by = 3'(n); lr = l; arith = a; rot = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    data_in = 8'($urandom); shift_by = 3'($urandom); lr = 1'($urandom);
    arith = 1'($urandom); rot = 1'($urandom);
    for (int k = 1; k <= n + 1; k++) begin
      @(negedge clk);
      cmp++;
      if (ready !== 1'(k > n)) begin
        mis++;
        $display("FAIL %s ready cycle %0d: got %b want %b", nm, k, ready, 1'(k > n));
      end
      cmp++;
      if (done !== 1'(k == n + 1)) begin
        mis++;
        $display("FAIL %s done cycle %0d: got %b want %b", nm, k, done, 1'(k == n + 1));
      end
      start = pulse && (k == 2);
    end
    cmp++;
    if (data_out !== ed) begin
      mis++;
      $display("FAIL %s data_out: got %h want %h", nm, data_out, ed);
    end
    cmp++;
    if (cout !== ec) begin
      mis++;
      $display("FAIL %s cout: got %b want %b", nm, cout, ec);
    end
  endtask

  task automatic idle_cycle();
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    cmp += 4;
    if (ready !== 1'b1)  begin mis++; $display("FAIL reset ready: got %b want 1", ready); end
    if (done !== 1'b0)   begin mis++; $display("FAIL reset done: got %b want 0", done); end
    if (data_out !== '0) begin mis++; $display("FAIL reset data_out: got %h want 00", data_out); end
    if (cout !== 1'b0)   begin mis++; $display("FAIL reset cout: got %b want 0", cout); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_op(8'h96, 3, 1'b0, 1'b0, 1'b0, 8'hB0, 1'b0, 1'b0, "left3");      idle_cycle();
    run_op(8'h96, 2, 1'b1, 1'b1, 1'b0, 8'hE5, 1'b1, 1'b0, "rarith2");    idle_cycle();
    run_op(8'h96, 2, 1'b1, 1'b0, 1'b0, 8'h25, 1'b1, 1'b0, "rlog2");      idle_cycle();
    run_op(8'h96, 7, 1'b1, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, "rlog7");      idle_cycle();
`ifdef SEQ_SHIFTER_ROTATE_EN
    run_op(8'h81, 1, 1'b0, 1'b0, 1'b1, 8'h03, 1'b1, 1'b0, "rotl1");      idle_cycle();
`else
    run_op(8'h81, 1, 1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0, "rotl1");      idle_cycle();
`endif
  endtask

  task automatic test_back_to_back();
    run_op(8'h5A, 0, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, "zero");
    run_op(8'h01, 1, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, "b2b_left1");
    run_op(8'h33, 0, 1'b1, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, "b2b_zero_a");
    run_op(8'hC4, 0, 1'b1, 1'b1, 1'b0, 8'hC4, 1'b0, 1'b0, "b2b_zero_b");
    idle_cycle();
  endtask

  task automatic test_ignore_start();
    run_op(8'hA7, 6, 1'b1, 1'b1, 1'b0, 8'hFE, 1'b1, 1'b1, "ignore_start");
    idle_cycle();
  endtask

  task automatic test_reset_abort();
    bit saw_done;
    data_in = 8'hC3; shift_by = 3'd6; lr = 1'b1; arith = 1'b0; rot = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    cmp += 4;
    if (ready !== 1'b1)  begin mis++; $display("FAIL abort ready: got %b want 1", ready); end
    if (data_out !== '0) begin mis++; $display("FAIL abort data_out: got %h want 00", data_out); end
    if (cout !== 1'b0)   begin mis++; $display("FAIL abort cout: got %b want 0", cout); end
    if (done !== 1'b0)   begin mis++; $display("FAIL abort done: got %b want 0", done); end
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done !== 1'b0) saw_done = 1'b1;
    end
    cmp++;
    if (saw_done) begin mis++; $display("FAIL abort late_done: got 1 want 0"); end
  endtask

  task automatic test_random();
    logic [W-1:0] d;
    int           n;
    logic         l, a, r;
    logic [W:0]   exp;
    for (int i = 0; i < 60; i++) begin
      d = 8'($urandom); n = int'($urandom_range(0, W - 1));
      l = 1'($urandom); a = 1'($urandom); r = 1'($urandom);
      exp = model(d, n, l, a, r);
      run_op(d, n, l, a, r, exp[W-1:0], exp[W], 1'($urandom), "random");
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_ignore_start();
    test_reset_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end

endmodule
